ram_sync_dp: RTL
================

RAM_SYNC_DP -- requirements
Module: ram_sync_dp

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits.
REQ-002 Parameter ADDR_W, default 5: address width in bits; depth DEPTH = 2**ADDR_W.
REQ-003 Parameter RD_MODE, default 0: same-address collision policy; 0 = read-first, 1 = write-first.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 ce  input  1  chip enable; gates all read and write activity.
REQ-007 we  input  1  write request.
REQ-008 waddr  input  ADDR_W  write address.
REQ-009 wdata  input  DATA_W  write data.
REQ-010 re  input  1  read request.
REQ-011 raddr  input  ADDR_W  read address.
REQ-012 clr  input  1  single-cycle request to zero the whole array.
REQ-013 rdata  output  DATA_W  registered read data.
REQ-014 rvalid  output  1  one-cycle strobe marking rdata as new.
REQ-015 busy  output  1  high while a clear sweep is in progress.
REQ-016 Separate unidirectional data ports; no tri-state bus.

Function
REQ-017 Storage is DEPTH words of DATA_W bits with independent write and read ports in the same clock domain.
REQ-018 Write: on an edge with ce=1, we=1, busy=0, mem[waddr] <= wdata.
REQ-019 Read: on an edge with ce=1, re=1, busy=0, rdata <= mem[raddr] and rvalid <= 1.
REQ-020 Read latency: exactly 1 cycle from the request edge to rdata and rvalid.
REQ-021 rvalid is 0 on every cycle without an accepted read; rdata holds its last value.
REQ-022 Collision (accepted read and write, raddr==waddr): RD_MODE=0 returns the old content; RD_MODE=1 returns wdata.
REQ-023 ce=0: no write, no read, rvalid=0; clr is still accepted.
REQ-024 FSM states are IDLE and CLEAR.
REQ-025 IDLE -> CLEAR when clr=1 is sampled; clear counter cnt <= 0; busy <= 1 on the same edge.
REQ-026 In CLEAR, each cycle writes mem[cnt] <= 0 and increments cnt.
REQ-027 CLEAR -> IDLE on the edge that writes address DEPTH-1; busy <= 0 on that edge.
REQ-028 busy is high for exactly DEPTH cycles.
REQ-029 While busy=1, we, re and clr are ignored and rvalid=0.
REQ-030 cnt is ADDR_W bits and does not wrap past DEPTH-1 within a sweep.
REQ-031 A read accepted on the edge where clr is sampled completes normally.
REQ-032 A write accepted on that same edge is performed and then overwritten by the sweep.

Reset
REQ-033 rst_n=0 forces immediately: rdata=0, rvalid=0, busy=0, state=IDLE, cnt=0.
REQ-034 Memory contents are not reset; they are undefined until written or cleared.
REQ-035 Reset during CLEAR aborts the sweep; addresses already swept stay 0 and the remaining addresses are unchanged.
REQ-036 Operation resumes on the first rising edge after rst_n returns to 1.

Verification (DATA_W=8, ADDR_W=5)
REQ-037 Write 12@3, 6@5, 9@4, then read 3, 5 back to back -> rdata 12 then 6, each with rvalid=1 one cycle after its request.
REQ-038 RD_MODE=0, mem[7]=1, same cycle write 2@7 and read 7 -> rdata=1; repeat with RD_MODE=1 -> rdata=2; a later read of 7 -> 2 in both modes.
REQ-039 After REQ-037 data, pulse clr -> busy=1 for exactly 32 cycles; a write 55@3 and a read issued during busy are ignored (rvalid=0); after busy falls, read 3 -> 0.
REQ-040 Start clr, assert rst_n=0 after 10 sweep cycles -> busy=0 and rvalid=0 immediately; addr 2 reads 0; addr 20 keeps its pre-clear value.
REQ-041 ce=0 with we=1 (write 77@9) and re=1 -> rvalid stays 0 and mem[9] is unchanged on a later ce=1 read.

Source files
------------

// File: rtl/ram_sync_dp_if.sv
// Bus bundle for the single-clock dual-port RAM: one write port, one read port,
// a clear request, and the registered read/status outputs.
interface ram_sync_dp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              ce;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic              clr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              busy;

    modport master (
        output ce, we, waddr, wdata, re, raddr, clr,
        input  rdata, rvalid, busy
    );

    modport slave (
        input  ce, we, waddr, wdata, re, raddr, clr,
        output rdata, rvalid, busy
    );
endinterface

// File: rtl/ram_sync_dp.sv
// Synchronous dual-port RAM (one write, one read port, one clock) with a
// selectable same-address collision policy and a background clear sweep.
module ram_sync_dp #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int RD_MODE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_sync_dp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              busy_w;
    logic              wr_acc;
    logic              rd_acc;
    logic              addr_hit;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write-first forwards the incoming word; read-first keeps the stored one.
    function automatic logic [DATA_W-1:0] collide_sel(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic              hit
    );
        if ((RD_MODE == 1) && hit) begin
            return new_word;
        end
        return old_word;
    endfunction

    assign busy_w   = (state_q == CLEAR);
    assign wr_acc   = bus.ce && bus.we && !busy_w;
    assign rd_acc   = bus.ce && bus.re && !busy_w;
    assign addr_hit = wr_acc && (bus.waddr == bus.raddr);
    assign rd_word  = collide_sel(mem[bus.raddr], bus.wdata, addr_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // clr is honoured regardless of ce; the counter parks on the last address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage has no reset; an aborted sweep leaves unswept words untouched.
    always_ff @(posedge clk) begin
        if (busy_w) begin
            mem[cnt_q] <= '0;
        end else if (wr_acc) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) begin
                rdata_q <= rd_word;
            end
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.busy   = busy_w;

endmodule
